// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO used in front of the UART serialiser.
// Latency: a pushed word is visible at rd_dat one cycle after the push edge.
// Backpressure: wr_rdy drops when full; a push while full is ignored even if a pop occurs on that edge.
// Ports: core_clk/rst (sync, active-high), wr_vld/wr_rdy/wr_dat write side,
//        rd_vld/rd_rdy/rd_dat read side (rd_dat = head), count = occupancy.
module fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          core_clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          wr_rdy,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   count
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;

  // Full/empty come from the registered count, so a pop on the same edge
  // never makes room for a push that arrived while full.
  assign wr_rdy = (count != DEPTH);
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;
  assign rd_dat = mem[rptr];

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_dat;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// Parametrised UART transmitter (data width, parity, stop bits, divisor) fed by a FIFO.
// Latency: start bit appears 2 cycles after i_DV is driven into an empty idle FIFO; frames run back-to-back.
// Backpressure: o_READY low when the FIFO is full; a word offered then is dropped and o_OVF pulses next cycle.
// Ports: i_CLK, i_RST (sync, active-high), i_DV/i_DATA write strobe and word (LSB first on the line),
//        o_READY, o_OVF, o_COUNT (FIFO occupancy), o_SERIAL (idles high), o_ACTIVE (frame in progress),
//        o_DONE (pulse on the final cycle of the last stop bit).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_DV,
  input  logic [DATA_BITS-1:0] i_DATA,
  output logic                 o_READY,
  output logic                 o_OVF,
  output logic [FIFO_AW:0]     o_COUNT,
  output logic                 o_SERIAL,
  output logic                 o_ACTIVE,
  output logic                 o_DONE
);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_AW < 1) begin : g_bad_aw
    $fatal(1, "uart_tx_fifo: FIFO_AW must be at least 1");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic [CW-1:0]          baud_cnt;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   fifo_vld;
  logic [DATA_BITS-1:0]   fifo_dat;
  logic                   bit_end, stop_last, pop;

  fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_fifo (
    .core_clk (i_CLK),
    .rst      (i_RST),
    .wr_vld   (i_DV),
    .wr_dat   (i_DATA),
    .wr_rdy   (o_READY),
    .rd_vld   (fifo_vld),
    .rd_rdy   (pop),
    .rd_dat   (fifo_dat),
    .count    (o_COUNT)
  );

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  // Pop from idle, or at the end of the last stop bit so the next start bit follows with no gap.
  assign pop = fifo_vld && ((state == S_IDLE) ||
                            (state == S_STOP && bit_end && stop_last));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      o_SERIAL <= 1'b1;
      o_ACTIVE <= 1'b0;
      o_DONE   <= 1'b0;
      o_OVF    <= 1'b0;
    end else begin
      o_OVF    <= i_DV && !o_READY;
      // Registered pulse: set on the edge that enters the final cycle of the last stop bit.
      o_DONE   <= (state == S_STOP) && stop_last && (baud_cnt == CNT_PRE);
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_q  <= fifo_dat;
            state    <= S_START;
            o_SERIAL <= 1'b0;
            o_ACTIVE <= 1'b1;
          end
        end
        S_START: if (bit_end) begin
          // shift_q still holds the whole latched word here.
          par_q    <= (PARITY == 1) ? ~^shift_q : ^shift_q;
          o_SERIAL <= shift_q[0];
          shift_q  <= shift_q >> 1;
          bit_idx  <= '0;
          state    <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
            if (PARITY != 0) begin
              o_SERIAL <= par_q;
              state    <= S_PARITY;
            end else begin
              o_SERIAL <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
            end
          end else begin
            bit_idx  <= bit_idx + 1'b1;
            o_SERIAL <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end
        end
        S_PARITY: if (bit_end) begin
          o_SERIAL <= 1'b1;
          stop_idx <= 1'b0;
          state    <= S_STOP;
        end
        S_STOP: if (bit_end) begin
          if (!stop_last) begin
            stop_idx <= 1'b1;
          end else if (pop) begin
            shift_q  <= fifo_dat;
            state    <= S_START;
            o_SERIAL <= 1'b0;
          end else begin
            state    <= S_IDLE;
            o_ACTIVE <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          o_SERIAL <= 1'b1;
          o_ACTIVE <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CPB  = 4;
  localparam int AW   = 2;
  localparam int DEP  = 4;
  localparam int NCFG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fin  = 0;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t got=%0h expected=%0h", name, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    // cfg0 8N1, cfg1 8E1, cfg2 7N2, cfg3 9O2, cfg4 5O1
    localparam int DB = (g == 2) ? 7 : (g == 3) ? 9 : (g == 4) ? 5 : 8;
    localparam int PM = (g == 1) ? 2 : (g >= 3) ? 1 : 0;
    localparam int SB = (g == 2 || g == 3) ? 2 : 1;
    localparam int PB = (PM != 0) ? 1 : 0;
    localparam int NB = 1 + DB + PB + SB;
    localparam int L  = NB * CPB;

    logic          rst, dv;
    logic [DB-1:0] dat;
    logic          ready, ovf, serial, active, done;
    logic [AW:0]   count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PM),
                   .STOP_BITS(SB), .FIFO_AW(AW)) dut (
      .i_CLK(clk), .i_RST(rst), .i_DV(dv), .i_DATA(dat),
      .o_READY(ready), .o_OVF(ovf), .o_COUNT(count),
      .o_SERIAL(serial), .o_ACTIVE(active), .o_DONE(done)
    );

    // Reference model: FIFO occupancy, cycles left in the frame on the line,
    // and the ordered list of accepted words still expected on the line.
    int            m_cnt, m_rem, m_pops;
    logic          m_ovf;
    logic [DB-1:0] q [$];

    task automatic cyc();
      logic acc, pp;
      @(posedge clk);
      if (rst) begin
        m_cnt = 0; m_rem = 0; m_ovf = 1'b0;
        q.delete();
      end else begin
        acc   = dv && (m_cnt < DEP);
        m_ovf = dv && !acc;
        pp    = (m_cnt > 0) && (m_rem <= 1);
        if (pp) begin
          m_rem = L;
          m_pops++;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        if (acc) q.push_back(dat);
        m_cnt = m_cnt + int'(acc) - int'(pp);
      end
      #1;
      check("count",  g, 32'(count),  32'(m_cnt));
      check("ready",  g, 32'(ready),  32'(m_cnt < DEP));
      check("ovf",    g, 32'(ovf),    32'(m_ovf));
      check("active", g, 32'(active), 32'(m_rem > 0));
      check("done",   g, 32'(done),   32'(m_rem == 1));
      if (m_rem == 0) check("idle_line", g, 32'(serial), 32'd1);
      if (m_rem == L) check("start_bit", g, 32'(serial), 32'd0);
    endtask

    task automatic drain();
      int n = 0;
      dv = 1'b0;
      while ((m_rem != 0 || m_cnt != 0) && n < 3000) begin
        cyc();
        n++;
      end
      cyc();
      cyc();
      check("all_frames_seen", g, 32'(q.size()), 32'd0);
    endtask

    // Stimulus
    initial begin
      logic [7:0] burst [6];
      int dens, base, n;
      burst = '{8'h4C, 8'h41, 8'h43, 8'h53, 8'h41, 8'h55};
      m_cnt = 0; m_rem = 0; m_ovf = 1'b0; m_pops = 0;
      rst = 1'b1; dv = 1'b0; dat = '0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      // single word
      dv = 1'b1; dat = DB'(8'h4C);
      cyc();
      dv = 1'b0;
      drain();
      // six-cycle burst into a four-deep FIFO: sixth word overflows
      for (int i = 0; i < 6; i++) begin
        dv = 1'b1; dat = DB'(burst[i]);
        cyc();
      end
      dv = 1'b0;
      drain();
      // random traffic at varying density
      for (int i = 0; i < 400; i++) begin
        dens = (i < 100) ? 80 : (i < 200) ? 5 : (i < 300) ? 30 : 100;
        dv  = ($urandom_range(0, 99) < dens);
        dat = DB'($urandom);
        cyc();
      end
      drain();
      // reset in the data phase of frame 2 of 3
      base = m_pops;
      for (int i = 0; i < 3; i++) begin
        dv = 1'b1; dat = DB'($urandom);
        cyc();
      end
      dv = 1'b0;
      n = 0;
      while (!(m_pops - base == 2 && m_rem == L - 3*CPB) && n < 1000) begin
        cyc();
        n++;
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
      // traffic after reset
      for (int i = 0; i < 40; i++) begin
        dv  = ($urandom_range(0, 99) < 50);
        dat = DB'($urandom);
        cyc();
      end
      drain();
      n_fin++;
    end

    // Line monitor: decodes each frame from o_SERIAL and scores it against the queue.
    initial begin
      logic [15:0]   got, e;
      logic          stable, aborted;
      logic [DB-1:0] wd;
      int            b, c, ones;
      forever begin
        @(negedge clk);
        if (serial === 1'b0 && rst === 1'b0) begin
          got = '0; stable = 1'b1; aborted = 1'b0; b = 0; c = 0;
          while (b < NB) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b0) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) got[b] = serial;
            else if (serial !== got[b]) stable = 1'b0;
            c++;
            if (c == CPB) begin
              c = 0;
              b++;
            end
          end
          if (!aborted) begin
            check("bit_stable", g, 32'(stable), 32'd1);
            if (q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_frame cfg%0d t=%0t got=%0h expected=no frame", g, $time, got);
            end else begin
              wd = q.pop_front();
              e  = '0;
              for (int i = 0; i < DB; i++) e[1+i] = wd[i];
              ones = $countones(wd);
              if (PB == 1) e[1+DB] = (PM == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
              for (int s = 0; s < SB; s++) e[1+DB+PB+s] = 1'b1;
              check("frame_bits", g, 32'(got), 32'(e));
            end
          end
        end
      end
    end
  end

  initial begin
    int n = 0;
    while (n_fin < NCFG && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n_fin < NCFG) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout finished=%0d expected=%0d", n_fin, NCFG);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the codebase's fixed 8N1 transmitter (uart_Tx). It adds configurable data width, parity mode, stop-bit count and baud divisor, and places an input FIFO in front of the serialiser. The FIFO lets upstream logic, such as a uart_Rx echo path, queue words without waiting for the line to go idle. Frames go out back-to-back while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 87, i_CLK cycles per serial bit; must be ≥2.
DATA_BITS, 8, data bits per frame; legal range 5-9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
i_CLK  in  1  system clock; single clock domain.
i_RST  in  1  synchronous, active-high reset.
i_DV  in  1  write strobe; one word per cycle while high.
i_DATA  in  DATA_BITS  word to transmit; sent LSB first.
o_READY  in→out  1  FIFO not full; i_DV is accepted only when this is high.
o_OVF  out  1  one-cycle pulse when i_DV arrives while o_READY=0; the word is dropped.
o_COUNT  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW.
o_SERIAL  out  1  TX line; idles high.
o_ACTIVE  out  1  high from the first start-bit cycle through the last stop-bit cycle.
o_DONE  out  1  one-cycle pulse on the final cycle of each frame's last stop bit.

(Corrected direction for o_READY: out.)

Behaviour:
- Reset (synchronous, i_RST high at a rising edge of i_CLK):
  - After the edge: o_SERIAL=1, o_ACTIVE=0, o_DONE=0, o_OVF=0, o_READY=1, o_COUNT=0.
  - FIFO pointers clear; the FSM goes to IDLE.
  - Reset mid-frame abandons the frame immediately: no truncated bits, and the line is high on the next cycle.
  - Queued words are discarded.
- FIFO:
  - Push when i_DV && o_READY at an edge.
  - o_READY = (o_COUNT != depth), derived from the registered count.
  - A push while full is rejected even if a pop happens on the same edge. o_OVF pulses in the following cycle.
  - Simultaneous push and pop leaves o_COUNT unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: o_SERIAL=1. At an edge with o_COUNT≠0, pop the head into the shift register, go to START, and drive o_SERIAL=0.
  - A word pushed into an empty FIFO while idle therefore starts its start bit 2 cycles after the push edge.
  - START: 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each lasting CLKS_PER_BIT cycles. The bit index counts 0..DATA_BITS-1.
  - PARITY: entered only when PARITY≠0.
    - Odd: bit = ~^data.
    - Even: bit = ^data.
    - Computed over the latched word, not the live FIFO head.
  - STOP: 1 for STOP_BITS×CLKS_PER_BIT cycles. o_DONE pulses on the final cycle.
    - At the next edge: if o_COUNT≠0, pop and enter START directly, with no idle gap.
    - Otherwise go to IDLE.
- Frame length in bits: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS. Duration is that value × CLKS_PER_BIT cycles.
- Baud counter:
  - Width: clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and resets on every bit transition.
- Line stability: o_SERIAL is registered and changes only at bit boundaries; no glitches.
- Illegal parameters (DATA_BITS outside 5-9, PARITY>2, STOP_BITS∉{1,2}): stop elaboration with a fatal error.

Test Plan:
1. CLKS_PER_BIT=4, 8N1. Push 0x4C once.
   - Start bit begins 2 cycles after the push.
   - Line: 0 | 0,0,1,1,0,0,1,0 | 1, each bit 4 cycles; 40 cycles total.
   - o_ACTIVE high for exactly 40 cycles; a single o_DONE pulse on cycle 40.
2. PARITY=2 (even), 0x4C (three 1s): parity bit=1, 44-cycle frame. PARITY=1 (odd), 0x41 (two 1s): parity bit=1. PARITY=2, 0x41: parity bit=0.
3. FIFO_AW=2, 8N1. Assert i_DV for 6 consecutive cycles with 0x4C, 0x41, 0x43, 0x53, 0x41, 0x55.
   - First 5 accepted (head popped on cycle 2); o_COUNT peaks at 4.
   - o_READY=0 and an o_OVF pulse on the 6th word; 0x55 never appears on the line.
   - Five frames of 40 cycles each run back-to-back with no high gap between frames; five o_DONE pulses.
4. STOP_BITS=2, DATA_BITS=7, no parity. Push 0x7F.
   - Line: 0 followed by seven 1s, then 8 cycles of stop at CLKS_PER_BIT=4.
   - o_DONE on the last stop cycle; the frame totals 40 cycles.
5. Assert i_RST for 1 cycle mid-DATA of frame 2 of 3 queued.
   - Next cycle: o_SERIAL=1, o_ACTIVE=0, o_COUNT=0.
   - No further frames; o_DONE never fires for the aborted frame.
6. Loopback: uart_tx_fifo (8N1, CLKS_PER_BIT=87) drives uart_Rx.
   - Push 0x4C, 0x41, 0x43, 0x53, 0x41 back-to-back.
   - uart_Rx o_DV asserts 5 times with o_BYTE matching in order.
